div_unit: RTL and testbench



---
 rtl/div_unit.sv | 127 ++++++++++++
 tb/tb_div_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider for MIPS DIV/DIVU; result = {remainder, quotient}.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration and completes in one cycle.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  input  logic        signed_div,
  input  logic        start,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready,
  output logic        busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic [63:0] result_q, result_d;

  logic        accept;
  logic [31:0] mag1, mag2;
  logic [32:0] rem_sh, diff;
  logic        trial_ok;
  logic [31:0] rem_nx, quo_nx, rem_fix, quo_fix;

  assign accept = start & ~annul;
  assign mag1   = (signed_div & num1[31]) ? -num1 : num1;
  assign mag2   = (signed_div & num2[31]) ? -num2 : num2;

  assign rem_sh = {rem_q, quo_q[31]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  // Partial remainder stays below the divisor, so a set shifted-out MSB means the shifted
  // value exceeds any 32-bit divisor; otherwise the 33-bit borrow decides.
  assign trial_ok = rem_sh[32] | ~diff[32];
  assign rem_nx   = trial_ok ? diff[31:0] : rem_sh[31:0];
  assign quo_nx   = {quo_q[30:0], trial_ok};

  // Remainder fix-up alone restores num1 on divide by zero; only the quotient is forced.
  assign rem_fix = rneg_q ? -rem_nx : rem_nx;
  assign quo_fix = dz_q ? 32'hFFFF_FFFF : (qneg_q ? -quo_nx : quo_nx);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          rem_d   = 32'd0;
          quo_d   = mag1;
          dvs_d   = mag2;
          qneg_d  = signed_div & (num1[31] ^ num2[31]);
          rneg_d  = signed_div & num1[31];
          dz_d    = (num2 == 32'd0);
          cnt_d   = 6'd0;
          state_d = StCalc;
`ifdef DIV_ZERO_FAST_EN
          if (num2 == 32'd0) begin
            state_d  = StDone;
            result_d = {num1, 32'hFFFF_FFFF};
          end
`endif
        end
      end
      StCalc: begin
        if (annul) begin
          state_d = StIdle;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d  = StDone;
            result_d = {rem_fix, quo_fix};
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 6'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvs_q    <= 32'd0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;
  assign ready  = (state_q == StDone);
  assign busy   = (state_q == StCalc) | ((state_q == StIdle) & accept);

endmodule

// File: tb/tb_div_unit.sv
// Randomized scoreboard bench for div_unit: driver pushes expected results, monitor pops on ready.
module tb_div_unit;

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] num1, num2;
  logic        signed_div, start, annul;
  logic [63:0] result;
  logic        ready, busy;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_res[$];
  int unsigned exp_cyc[$];
  logic [63:0] last_exp = 64'd0;

  div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .num1      (num1),
    .num2      (num2),
    .signed_div(signed_div),
    .start     (start),
    .annul     (annul),
    .result    (result),
    .ready     (ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!s) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [63:0] er;
    int unsigned ec;
    if (!rst && ready) begin
      checks++;
      if (exp_res.size() == 0) begin
        errors++;
        $display("FAIL ready_unexpected actual=ready@%0d result=%h required=no_pulse", cyc, result);
      end else begin
        er = exp_res.pop_front();
        ec = exp_cyc.pop_front();
        if (result !== er) begin
          errors++;
          $display("FAIL result actual=%h required=%h", result, er);
        end
        checks++;
        if (cyc != ec) begin
          errors++;
          $display("FAIL latency actual=cycle %0d required=cycle %0d", cyc, ec);
        end
      end
    end
  end

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    num1 = a; num2 = b; signed_div = s; start = 1'b1; annul = 1'b0;
    #1 check("busy_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s,
                    input bit noise);
    int n;
    int exp_n;
    launch(a, b, s);
    exp_n = (FAST && b == 32'd0) ? 0 : 32;
    exp_res.push_back(ref_div(a, b, s));
    exp_cyc.push_back(cyc + 1 + exp_n);
    last_exp = ref_div(a, b, s);
    @(posedge clk);
    #1 start = 1'b0; num1 = $urandom; num2 = $urandom; signed_div = 1'($urandom);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (noise && i == 5) start = 1'b1;
      if (noise && i == 6) start = 1'b0;
    end
    check("busy_len", 64'(n), 64'(exp_n));
  endtask

  task automatic annul_op(input logic [31:0] a, input logic [31:0] b);
    launch(a, b, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1 annul = 1'b0;
    check("annul_idle_busy", {63'd0, busy}, 64'd0);
    check("annul_result_hold", result, last_exp);
  endtask

  task automatic reset_mid_op(input logic [31:0] a, input logic [31:0] b);
    launch(a, b, 1'b1);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_result", result, 64'd0);
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    exp_res.delete();
    exp_cyc.delete();
    last_exp = 64'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b;
    rst = 1'b1; num1 = '0; num2 = '0; signed_div = 1'b0; start = 1'b0; annul = 1'b0;
    #1;
    check("reset_result", result, 64'd0);
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    op(32'd100, 32'd7, 1'b0, 1'b0);
    op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    op(32'h1234_5678, 32'd0, 1'b0, 1'b0);
    op(32'h8765_4321, 32'd0, 1'b1, 1'b0);
    op(32'h8000_0000, 32'd0, 1'b1, 1'b0);
    op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);

    annul_op(32'hDEAD_BEEF, 32'd3);
    op(32'd1000, 32'd33, 1'b0, 1'b1);

    reset_mid_op(32'h7FFF_FFFF, 32'd5);
    op(32'd9, 32'd3, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = -$urandom_range(1, 15);
        3: a = $urandom_range(0, 100);
        default: ;
      endcase
      op(a, b, 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    check("sb_drained", 64'(exp_res.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
